// File: rtl/front_turbo_pkg.sv
// Shared definitions for the front/turbo object scanner: FSM states, object RAM
// layout and the draw descriptor handed to the line-buffer drawer.
package front_turbo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ATTR,
    S_RD_Y,
    S_TEST,
    S_RD_TILE,
    S_PUSH,
    S_DONE
  } scan_state_e;

  localparam int ATTR_Y8    = 4;
  localparam int ATTR_X8    = 5;
  localparam int ATTR_FLIPY = 6;

  localparam logic [1:0] OFS_TILE = 2'd0;
  localparam logic [1:0] OFS_ATTR = 2'd1;
  localparam logic [1:0] OFS_Y    = 2'd2;
  localparam logic [1:0] OFS_X    = 2'd3;

  typedef struct packed {
    logic [7:0] tile;
    logic [3:0] color;
    logic [8:0] x;
    logic [3:0] row;
  } desc_t;

  function automatic logic [7:0] obj_addr(input logic [5:0] idx, input logic [1:0] ofs);
    return {idx, ofs};
  endfunction

endpackage

// File: rtl/front_turbo_desc_fifo.sv
// Descriptor FIFO between scanner and drawer. Flush has priority over push/pop;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module front_turbo_desc_fifo
  import front_turbo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  push_i,
  input  desc_t push_desc_i,
  output logic  push_ok_o,
  input  logic  pop_i,
  output logic  valid_o,
  output desc_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop_ok;
  desc_t         mem_q [DEPTH];

  assign valid_o   = (cnt_q != '0);
  assign pop_ok    = pop_i && valid_o;
  assign push_ok_o = push_i && ((cnt_q < CW'(DEPTH)) || pop_ok);
  // Empty FIFO presents all-zero fields so the outputs are defined after reset.
  assign head_o    = valid_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok_o) wr_q <= wr_q + 1'b1;
      if (pop_ok)    rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok_o) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o && !flush_i) mem_q[wr_q] <= push_desc_i;
  end

endmodule

// File: rtl/front_turbo_obj_scan.sv
// Per-scanline object scanner: walks attribute RAM, applies the 9-bit vertical
// window test and queues one draw descriptor per visible object.
module front_turbo_obj_scan
  import front_turbo_pkg::*;
#(
  parameter int OBJ_COUNT  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic [8:0] line,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_tile,
  output logic [3:0] out_color,
  output logic [8:0] out_x,
  output logic [3:0] out_row,
  output logic       scan_done,
  output logic       overrun
);

  scan_state_e state_q;
  logic [5:0]  idx_q;
  logic [7:0]  ram_addr_q;
  logic        scan_done_q;
  logic        overrun_q;
  logic [8:0]  line_q;
  logic [6:0]  attr_q;
  logic [7:0]  x_q;
  logic [3:0]  row_q;

  logic [8:0]  row9;
  logic        hit;
  logic        last_obj;
  logic        push_req;
  logic        push_ok;
  logic        advance;
  desc_t       push_desc;
  desc_t       head;

  // Y arrives live on ram_data during TEST; wrap modulo 512 is the natural 9-bit subtract.
  assign row9     = line_q - {attr_q[ATTR_Y8], ram_data};
  assign hit      = (row9[8:4] == 5'd0);
  assign last_obj = (idx_q == 6'(OBJ_COUNT - 1));
  assign push_req = (state_q == S_PUSH) && !line_start;
  assign advance  = ((state_q == S_TEST) && !hit) || ((state_q == S_PUSH) && push_ok);

  assign push_desc = '{tile:  ram_data,
                       color: attr_q[3:0],
                       x:     {attr_q[ATTR_X8], x_q},
                       row:   row_q};

  always_ff @(posedge clk) begin
    if (line_start)                 line_q <= line;
    if (state_q == S_RD_Y)          attr_q <= ram_data[6:0];
    if (state_q == S_TEST && hit)   row_q  <= attr_q[ATTR_FLIPY] ? ~row9[3:0] : row9[3:0];
    if (state_q == S_RD_TILE)       x_q    <= ram_data;
  end

  // ram_addr is registered on entry to each state so it is valid for the whole state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ram_addr_q  <= '0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (line_start) begin
        overrun_q   <= !(state_q inside {S_IDLE, S_DONE});
        idx_q       <= '0;
        scan_done_q <= 1'b0;
        state_q     <= S_RD_ATTR;
        ram_addr_q  <= obj_addr(6'd0, OFS_ATTR);
      end else if (advance) begin
        if (last_obj) begin
          state_q     <= S_DONE;
          scan_done_q <= 1'b1;
        end else begin
          idx_q      <= idx_q + 6'd1;
          state_q    <= S_RD_ATTR;
          ram_addr_q <= obj_addr(idx_q + 6'd1, OFS_ATTR);
        end
      end else begin
        case (state_q)
          S_RD_ATTR: begin
            state_q    <= S_RD_Y;
            ram_addr_q <= obj_addr(idx_q, OFS_Y);
          end
          S_RD_Y: begin
            state_q    <= S_TEST;
            ram_addr_q <= obj_addr(idx_q, OFS_X);
          end
          S_TEST: begin
            state_q    <= S_RD_TILE;
            ram_addr_q <= obj_addr(idx_q, OFS_TILE);
          end
          S_RD_TILE: state_q <= S_PUSH;
          default: ;
        endcase
      end
    end
  end

  front_turbo_desc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .flush_i     (line_start),
    .push_i      (push_req),
    .push_desc_i (push_desc),
    .push_ok_o   (push_ok),
    .pop_i       (out_ready),
    .valid_o     (out_valid),
    .head_o      (head)
  );

  assign ram_addr  = ram_addr_q;
  assign scan_done = scan_done_q;
  assign overrun   = overrun_q;
  assign out_tile  = head.tile;
  assign out_color = head.color;
  assign out_x     = head.x;
  assign out_row   = head.row;

endmodule
